// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle LSB-first subtractor processing STEP bits per clock with a registered borrow.
// Define SERIAL_SUB_BRIN_EN to add the brin borrow-in port for multi-word chaining.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BRIN_EN
  input  logic             brin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             brout,
  output logic             ovf
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
  logic             bor_q, bor_d, sa_q, sa_d, sb_q, sb_d, brout_q, brout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [STEP:0]    slice;
  logic             bin;
`ifdef SERIAL_SUB_BRIN_EN
  assign bin = brin;
`else
  assign bin = 1'b0;
`endif
  // Low STEP bits of each operand minus the carried borrow; the extra MSB is the borrow out.
  assign slice = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]} - {{STEP{1'b0}}, bor_q};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    bor_d   = bor_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    brout_d = brout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      a_d   = a_q >> STEP;
      b_d   = b_q >> STEP;
      r_d   = (r_q >> STEP) | (WIDTH'(slice[STEP-1:0]) << (WIDTH - STEP));
      bor_d = slice[STEP];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        state_d = DONE;
        d_d     = r_d;
        brout_d = slice[STEP];
        ovf_d   = (sa_q != sb_q) && (r_d[WIDTH-1] != sa_q);
      end
    end else if (start) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      sa_d    = a[WIDTH-1];
      sb_d    = b[WIDTH-1];
      bor_d   = bin;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      bor_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      brout_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      bor_q   <= bor_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      brout_q <= brout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy  = state_q == RUN;
  assign done  = state_q == DONE;
  assign d     = d_q;
  assign brout = brout_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor with STEP=1 and STEP=4 instances.
module tb_serial_subtractor;
  typedef struct packed {logic [7:0] d; logic br; logic ov;} exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start4 = 1'b0;
  logic [7:0] a = '0, b = '0, d, d4;
  logic       busy, done, brout, ovf, busy4, done4, brout4, ovf4;
`ifdef SERIAL_SUB_BRIN_EN
  logic       brin = 1'b0;
`endif
  exp_t       q[$];
  int         cmp = 0, err = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_SUB_BRIN_EN
    .brin(brin),
`endif
    .busy(busy), .done(done), .d(d), .brout(brout), .ovf(ovf));
  serial_subtractor #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b),
`ifdef SERIAL_SUB_BRIN_EN
    .brin(brin),
`endif
    .busy(busy4), .done(done4), .d(d4), .brout(brout4), .ovf(ovf4));
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] t;
    exp_t e;
    t = {1'b0, x} - {1'b0, y} - {8'b0, bi};
    e.d = t[7:0];
    e.br = t[8];
    e.ov = (x[7] != y[7]) && (t[7] != x[7]);
    return e;
  endfunction
  task automatic issue(input bit s4, input bit hold, input logic [7:0] x, input logic [7:0] y, input logic bi);
    a = x;
    b = y;
`ifdef SERIAL_SUB_BRIN_EN
    brin = bi;
    q.push_back(model(x, y, bi));
`else
    q.push_back(model(x, y, 1'b0));
`endif
    if (s4) start4 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      start4 = 1'b0;
    end
  endtask
  task automatic wait_done(input bit s4, output int bc, output bit ok, output bit ovl);
    bc = 0;
    ok = 1'b0;
    ovl = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((s4 ? busy4 : busy) && (s4 ? done4 : done)) ovl = 1'b1;
      if (s4 ? done4 : done) ok = 1'b1;
      else begin
        if (s4 ? busy4 : busy) bc++;
        @(negedge clk);
      end
    end
  endtask
  task automatic test_reset;
    #2;
    cmp++;
    if ({busy, done, d, brout, ovf} !== 11'b0) begin
      err++;
      $display("FAIL reset_state: got busy=%b done=%b d=%h br=%b ov=%b want all 0", busy, done, d, brout, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic;
    logic [7:0] ta [3] = '{8'h05, 8'h03, 8'h80};
    logic [7:0] tb [3] = '{8'h03, 8'h05, 8'h01};
    exp_t       want [3] = '{'{8'h02, 1'b0, 1'b0}, '{8'hFE, 1'b1, 1'b0}, '{8'h7F, 1'b0, 1'b1}};
    exp_t       e, got;
    int         bc;
    bit         ok, ovl;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, ta[i], tb[i], 1'b0);
      wait_done(1'b0, bc, ok, ovl);
      cmp++;
      if (!ok || bc != 8 || ovl) begin
        err++;
        $display("FAIL basic_timing[%0d]: busy_cycles=%0d done_seen=%b overlap=%b want 8/1/0", i, bc, ok, ovl);
      end
      got = {d, brout, ovf};
      e = q.pop_front();
      cmp++;
      if (got !== e || got !== want[i]) begin
        err++;
        $display("FAIL basic_result[%0d]: got %h/%b/%b want %h/%b/%b", i, got.d, got.br, got.ov, want[i].d, want[i].br, want[i].ov);
      end
      @(negedge clk);
      cmp++;
      if (done !== 1'b0 || d !== want[i].d) begin
        err++;
        $display("FAIL basic_done_pulse[%0d]: got done=%b d=%h want 0/%h", i, done, d, want[i].d);
      end
    end
  endtask
  task automatic test_start_ignored;
    exp_t e, got;
    int   bc;
    bit   ok, ovl;
    issue(1'b0, 1'b0, 8'h9C, 8'h31, 1'b0);
    @(negedge clk);
    a = 8'h11;
    b = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, bc, ok, ovl);
    cmp++;
    if (!ok || bc != 6 || ovl) begin
      err++;
      $display("FAIL ignore_timing: busy_cycles=%0d done_seen=%b overlap=%b want 6/1/0", bc, ok, ovl);
    end
    got = {d, brout, ovf};
    e = q.pop_front();
    cmp++;
    if (got !== e) begin
      err++;
      $display("FAIL ignore_result: got %h/%b/%b want %h/%b/%b", got.d, got.br, got.ov, e.d, e.br, e.ov);
    end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    exp_t e, got;
    int   bc;
    bit   ok, ovl;
    issue(1'b0, 1'b1, 8'h40, 8'h41, 1'b0);
    a = 8'h7F;
    b = 8'hFF;
    q.push_back(model(8'h7F, 8'hFF, 1'b0));
    wait_done(1'b0, bc, ok, ovl);
    got = {d, brout, ovf};
    e = q.pop_front();
    cmp++;
    if (!ok || got !== e) begin
      err++;
      $display("FAIL b2b_first: got %h/%b/%b done_seen=%b want %h/%b/%b", got.d, got.br, got.ov, ok, e.d, e.br, e.ov);
    end
    @(negedge clk);
    start = 1'b0;
    cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      err++;
      $display("FAIL b2b_no_idle: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(1'b0, bc, ok, ovl);
    cmp++;
    if (!ok || bc != 8 || ovl) begin
      err++;
      $display("FAIL b2b_timing: busy_cycles=%0d done_seen=%b overlap=%b want 8/1/0", bc, ok, ovl);
    end
    got = {d, brout, ovf};
    e = q.pop_front();
    cmp++;
    if (got !== e) begin
      err++;
      $display("FAIL b2b_second: got %h/%b/%b want %h/%b/%b", got.d, got.br, got.ov, e.d, e.br, e.ov);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_run;
    exp_t e, got;
    int   bc;
    bit   ok, ovl, seen;
    issue(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
    void'(q.pop_back());
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({busy, done, d, brout, ovf} !== 11'b0) begin
      err++;
      $display("FAIL async_reset: got busy=%b done=%b d=%h br=%b ov=%b want all 0", busy, done, d, brout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    cmp++;
    if (seen) begin
      err++;
      $display("FAIL reset_abandon: got done/busy activity=1 want 0");
    end
    issue(1'b0, 1'b0, 8'hC8, 8'h64, 1'b0);
    wait_done(1'b0, bc, ok, ovl);
    got = {d, brout, ovf};
    e = q.pop_front();
    cmp++;
    if (!ok || bc != 8 || got !== e) begin
      err++;
      $display("FAIL reset_recover: got %h/%b/%b busy_cycles=%0d want %h/%b/%b 8", got.d, got.br, got.ov, bc, e.d, e.br, e.ov);
    end
    @(negedge clk);
  endtask
  task automatic test_step4;
    exp_t e, got;
    int   bc;
    bit   ok, ovl;
    issue(1'b1, 1'b0, 8'hA5, 8'h5A, 1'b0);
    wait_done(1'b1, bc, ok, ovl);
    cmp++;
    if (!ok || bc != 2 || ovl) begin
      err++;
      $display("FAIL step4_timing: busy_cycles=%0d done_seen=%b overlap=%b want 2/1/0", bc, ok, ovl);
    end
    got = {d4, brout4, ovf4};
    e = q.pop_front();
    cmp++;
    if (got !== e || got !== exp_t'({8'h4B, 1'b0, 1'b1})) begin
      err++;
      $display("FAIL step4_result: got %h/%b/%b want 4b/0/1", got.d, got.br, got.ov);
    end
    @(negedge clk);
  endtask
`ifdef SERIAL_SUB_BRIN_EN
  task automatic test_brin;
    exp_t got;
    int   bc;
    bit   ok, ovl;
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    brin = 1'b0;
    wait_done(1'b0, bc, ok, ovl);
    got = {d, brout, ovf};
    void'(q.pop_front());
    cmp++;
    if (!ok || got !== exp_t'({8'hFF, 1'b1, 1'b0})) begin
      err++;
      $display("FAIL brin_result: got %h/%b/%b want ff/1/0", got.d, got.br, got.ov);
    end
    @(negedge clk);
  endtask
`endif
  task automatic test_random;
    exp_t e, got;
    int   bc;
    bit   ok, ovl, s4;
    for (int i = 0; i < 10; i++) begin
      s4 = i[0];
      issue(s4, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      wait_done(s4, bc, ok, ovl);
      got = s4 ? {d4, brout4, ovf4} : {d, brout, ovf};
      e = q.pop_front();
      cmp++;
      if (!ok || ovl || bc != (s4 ? 2 : 8) || got !== e) begin
        err++;
        $display("FAIL random[%0d]: got %h/%b/%b busy_cycles=%0d want %h/%b/%b %0d", i, got.d, got.br, got.ov, bc, e.d, e.br, e.ov, s4 ? 2 : 8);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    test_step4;
`ifdef SERIAL_SUB_BRIN_EN
    test_brin;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
